// File: rtl/fir_capture.sv
// fir_capture: captures a run of FIR output samples into a local buffer and replays them.
//   clk, rst        : clock, asynchronous active-low reset
//   y_rsc_dat       : FIR output sample, written to the buffer in every capture cycle
//   arm             : start pulse, accepted only while idle
//   skip_cycles     : cycles to discard after arm (latched on arm)
//   num_samples     : run length (latched on arm, clipped to DEPTH)
//   rd_valid/rd_ready/rd_data/rd_last : replay read port
//   busy            : run in progress
//   done            : one-cycle pulse after the final read transfer
//   sum             : modulo-2^DATA_W sum of the samples captured in the current/last run
module fir_capture #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] y_rsc_dat,
  input  logic              arm,
  input  logic [7:0]        skip_cycles,
  input  logic [CNT_W-1:0]  num_samples,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] sum
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, SKIP, CAPT, DRAIN} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [7:0]         skip_cnt;
  logic [CNT_W-1:0]   n_lat;
  logic [CNT_W-1:0]   n_clip;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [DATA_W-1:0]  sum_q;
  logic               done_q;
  logic [DATA_W-1:0]  mem [DEPTH];

  logic               arm_go;
  logic               arm_empty;
  logic               wr_last;
  logic               rd_last_c;
  logic               rd_xfer;

  // Run-length clip and control decodes
  assign n_clip    = (num_samples > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : num_samples;
  assign arm_go    = (state == IDLE) && arm;
  assign arm_empty = arm_go && (n_clip == '0);
  assign wr_last   = (CNT_W'(wr_ptr) == (n_lat - CNT_W'(1)));
  assign rd_last_c = (state == DRAIN) && (CNT_W'(rd_ptr) == (n_lat - CNT_W'(1)));
  assign rd_xfer   = (state == DRAIN) && rd_ready;

  // Read port and status are decoded straight from registered state
  assign rd_valid = (state == DRAIN);
  assign rd_last  = rd_last_c;
  assign rd_data  = mem[rd_ptr];
  assign busy     = (state != IDLE);
  assign done     = done_q;
  assign sum      = sum_q;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (arm_go && !arm_empty) state_nxt = (skip_cycles != 8'd0) ? SKIP : CAPT;
      SKIP:  if (skip_cnt == 8'd1)      state_nxt = CAPT;
      CAPT:  if (wr_last)               state_nxt = DRAIN;
      DRAIN: if (rd_xfer && rd_last_c)  state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  // Counters, pointers, checksum and done pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skip_cnt <= 8'd0;
      n_lat    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      sum_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= arm_empty || (rd_xfer && rd_last_c);
      if (arm_go) begin
        skip_cnt <= skip_cycles;
        n_lat    <= n_clip;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        sum_q    <= '0;
      end
      if (state == SKIP) skip_cnt <= skip_cnt - 8'd1;
      if (state == CAPT) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        sum_q  <= sum_q + y_rsc_dat;
      end
      if (rd_xfer) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Sample buffer; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (state == CAPT) mem[wr_ptr] <= y_rsc_dat;
  end

endmodule

// File: tb/tb_fir_capture.sv
// tb_fir_capture: randomized and directed bench for fir_capture with a sample-index reference model.
module tb_fir_capture;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned CNT_W  = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [DATA_W-1:0] y_rsc_dat = '0;
  logic              arm = 1'b0;
  logic [7:0]        skip_cycles = '0;
  logic [CNT_W-1:0]  num_samples = '0;
  logic              rd_valid;
  logic              rd_ready = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] sum;

  int total = 0;
  int bad   = 0;

  fir_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .y_rsc_dat(y_rsc_dat), .arm(arm),
    .skip_cycles(skip_cycles), .num_samples(num_samples),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_last(rd_last), .busy(busy), .done(done), .sum(sum)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // One run: arm at an edge, feed y per edge, then drain. The model takes sample i
  // from the value presented at edge arm+1+skip+i and sums it modulo 2^32.
  // ymode: 0 random, 1 base+j (j=0 at arm edge), 2 wrap pair then random.
  // rmode: 0 ready held high, 1 pattern 1,0,0,1,0,1,1, 2 random.
  task automatic run(input int s, input int n, input int ymode, input logic [31:0] base,
                     input int rmode, input bit noise);
    int neff;
    int idx;
    int c;
    logic [31:0] yv [0:299];
    logic [31:0] expq [$];
    logic [31:0] esum;
    bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    neff = (n > int'(DEPTH)) ? int'(DEPTH) : n;
    for (int j = 0; j <= s + neff + 1; j++) begin
      if (ymode == 1)      yv[j] = base + 32'(j);
      else if (ymode == 2) yv[j] = (j == 1) ? 32'hFFFF_FFFF : ((j == 2) ? 32'd2 : $urandom);
      else                 yv[j] = $urandom;
    end
    esum = '0;
    for (int i = 0; i < neff; i++) begin
      expq.push_back(yv[1 + s + i]);
      esum = esum + yv[1 + s + i];
    end

    @(negedge clk);
    arm = 1'b1; skip_cycles = 8'(s); num_samples = 5'(n); y_rsc_dat = yv[0]; rd_ready = 1'b0;
    @(negedge clk);
    arm = 1'b0;
    if (neff == 0) begin
      chk("empty_done", 32'(done), 32'd1);
      chk("empty_busy", 32'(busy), 32'd0);
      chk("empty_sum", sum, 32'd0);
      chk("empty_valid", 32'(rd_valid), 32'd0);
      @(negedge clk);
      chk("empty_done_off", 32'(done), 32'd0);
      return;
    end
    chk("busy_rise", 32'(busy), 32'd1);
    for (int j = 1; j <= s + neff; j++) begin
      y_rsc_dat = yv[j];
      if (noise) begin
        arm = 1'($urandom_range(0, 1)); skip_cycles = 8'($urandom); num_samples = 5'($urandom);
      end
      chk("fill_valid", 32'(rd_valid), 32'd0);
      chk("fill_busy", 32'(busy), 32'd1);
      @(negedge clk);
    end
    arm = 1'b0;
    y_rsc_dat = $urandom;
    chk("drain_valid", 32'(rd_valid), 32'd1);
    chk("sum_final", sum, esum);

    idx = 0;
    c = 0;
    while (idx < neff && c < 200) begin
      if (rmode == 0)      rd_ready = 1'b1;
      else if (rmode == 1) rd_ready = pat[c % 7];
      else                 rd_ready = 1'($urandom_range(0, 1));
      if (noise) arm = 1'($urandom_range(0, 1));
      chk("rd_valid", 32'(rd_valid), 32'd1);
      chk("rd_data", rd_data, expq[idx]);
      chk("rd_last", 32'(rd_last), 32'(idx == neff - 1));
      chk("drain_busy", 32'(busy), 32'd1);
      if (rd_ready) idx++;
      c++;
      @(negedge clk);
    end
    if (idx < neff) chk("drain_timeout", 32'(idx), 32'(neff));
    arm = 1'b0;
    rd_ready = 1'b0;
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_valid", 32'(rd_valid), 32'd0);
    chk("sum_hold", sum, esum);
    @(negedge clk);
    chk("done_off", 32'(done), 32'd0);
    chk("sum_hold2", sum, esum);
  endtask

  initial begin
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_last", 32'(rd_last), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", sum, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run(0, 5, 1, 32'd0, 0, 1'b0);     // reads 1..5, sum 15
    run(3, 2, 1, 32'd10, 0, 1'b0);    // captures 14, 15
    run(2, 4, 0, 32'd0, 1, 1'b0);     // backpressure pattern
    run(0, 0, 0, 32'd0, 0, 1'b0);     // empty run
    run(1, 20, 0, 32'd0, 0, 1'b0);    // clipped to DEPTH
    run(0, 2, 2, 32'd0, 0, 1'b0);     // wrap sum = 1
    run(2, 6, 0, 32'd0, 2, 1'b1);     // stray arms ignored

    // Reset in the middle of a capture
    @(negedge clk);
    arm = 1'b1; skip_cycles = 8'd0; num_samples = 5'd8; y_rsc_dat = 32'h1234;
    @(negedge clk);
    arm = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    chk("pre_rst_sum", sum, 32'h1234 * 3);
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(rd_valid), 32'd0);
    chk("mid_rst_sum", sum, 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run(0, 1, 1, 32'd6, 0, 1'b0);     // reads 7

    for (int t = 0; t < 15; t++) begin
      run(int'($urandom_range(0, 6)), int'($urandom_range(0, 20)), 0, 32'd0,
          int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fir_capture.md
# fir_capture

Output-side capture block for the FIR datapath: it samples the filter's `y_rsc_dat` stream into a local buffer and replays it through a valid/ready read port. It is armed by a pulse and skips a programmable number of cycles to absorb filter latency. It captures a programmable number of consecutive output samples and accumulates a wrap-around checksum. It sits at the `fir` output, mirroring the stimulus side that drives `x_rsc_dat`, so benches and on-chip debug can read filter results back.

## Interface

- `DATA_W`, 32: sample width, equal to the `y_rsc_dat` width.
- `DEPTH`, 16: buffer depth in samples; must be a power of two, ≥2.
- `CNT_W`, $clog2(DEPTH+1): width of `num_samples`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `y_rsc_dat` in DATA_W: FIR output sample, sampled every capture cycle.
- `arm` in 1: start pulse; honoured only in IDLE.
- `skip_cycles` in 8: cycles to discard after arm; latched on arm.
- `num_samples` in CNT_W: samples to capture; latched on arm and clipped to DEPTH.
- `rd_valid` out 1: read data available.
- `rd_ready` in 1: consumer accepts `rd_data`.
- `rd_data` out DATA_W: current buffered sample.
- `rd_last` out 1: high with the final sample of the run.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse after the final read transfer.
- `sum` out DATA_W: modulo-2^DATA_W sum of the samples captured in the current or last run.

## Operation

- States are IDLE, SKIP, CAPT and DRAIN.
- **IDLE**
  - `arm` high at an edge latches `skip_cycles` and N = min(`num_samples`, DEPTH), clears `sum` and resets the write and read pointers.
  - Next state is SKIP if the latched skip is greater than 0, otherwise CAPT.
  - If N = 0, the block goes directly to IDLE and pulses `done` next cycle, with `sum` = 0.
- **SKIP**
  - A down-counter decrements once per edge.
  - The block moves to CAPT on the edge where the counter reaches 0.
  - `y_rsc_dat` is ignored.
- **CAPT**
  - At each edge, `y_rsc_dat` is written to buf[wr_ptr], `wr_ptr` increments and `sum` += `y_rsc_dat`.
  - After the Nth write, the block moves to DRAIN.
- **DRAIN**
  - `rd_valid` = 1 and `rd_data` = buf[rd_ptr].
  - `rd_last` = (`rd_ptr` == N−1).
  - A transfer occurs when `rd_valid` and `rd_ready` are both high at an edge; `rd_ptr` then increments.
  - The transfer with `rd_last` high returns the block to IDLE and raises `done` for the next cycle.
- `arm` outside IDLE is ignored, including `arm` on the same edge as the final transfer.
- The pointers never wrap within a run because N ≤ DEPTH.
- `sum` holds its value after the run until the next accepted `arm`.
- Buffer contents are not reset; `rd_data` is don't-care while `rd_valid` = 0.
- Reset (`rst` low, at any time, including mid-SKIP/CAPT/DRAIN) forces the following immediately:
  - state = IDLE, with the counters and pointers at 0;
  - `rd_valid` = 0, `rd_last` = 0, `busy` = 0, `done` = 0 and `sum` = 0.

## Timing

- `arm` high at edge k causes the first captured sample to be `y_rsc_dat` as sampled at edge k+1+S, where S is the latched skip.
- Sample i (0-based) is sampled at edge k+1+S+i.
- `busy` rises in the cycle after edge k.
- `rd_valid` rises in the cycle after the last capture edge (k+S+N); the first transfer is possible at edge k+S+N+1.
- With `rd_ready` held high, one sample transfers per cycle and DRAIN lasts N cycles.
- `rd_valid`, `rd_data` and `rd_last` are stable while `rd_valid` = 1 and `rd_ready` = 0.
- `done` is high for exactly the one cycle following the final transfer; `busy` is low in that cycle.
- `sum` updates one edge after each sample is captured and is final in the first DRAIN cycle.
- The block is combinationally transparent from `rd_ready` to nothing; all outputs are registered or decoded from state.

## Test plan

- Basic run: reset, then `arm` with skip=0 and N=5, driving `y_rsc_dat` = 1,2,3,4,5 on consecutive edges with `rd_ready` = 1.
  - Required: reads 1,2,3,4,5, `rd_last` on 5, `sum` = 15, then a single `done` pulse.
- Latency skip: skip=3 and N=2, with `y_rsc_dat` counting 10,11,12,… from the arm edge onward.
  - Required: captures 14 and 15, and `sum` = 29.
- Backpressure: N=4, toggling `rd_ready` 1,0,0,1,0,1,1.
  - Required: data is held stable while stalled, the order is preserved, and exactly 4 transfers occur before `done`.
- Limits: N=0 returns to IDLE with `done` and `sum` = 0; N=20 with DEPTH=16 captures exactly 16.
  - The 32-bit wrap case `y_rsc_dat` = 0xFFFF_FFFF, 2 gives `sum` = 1.
- Ignored arm and reset: `arm` pulses during SKIP, CAPT and DRAIN have no effect.
  - Asserting `rst` low mid-CAPT clears `busy`, `rd_valid` and `sum` immediately.
  - After `rst` releases, a new `arm` with N=1 and `y_rsc_dat` = 7 reads 7.
